// File: rtl/store_w_gate_if.sv
// Bundle of the store-unit-facing and AXI-facing handshake signals around the W gate.
// "slave" is the gate's view, "master" is the surrounding environment's view.
interface store_w_gate_if #(
   parameter int AxiDataWidth   = 128,
   parameter int MaxOutstanding = 8,
   parameter int LenWidth       = 8
);
   localparam int StrbWidth = AxiDataWidth / 8;
   localparam int CntW      = $clog2(MaxOutstanding) + 1;

   logic                    aw_valid_i;
   logic                    aw_ready_o;
   logic [LenWidth-1:0]     aw_len_i;
   logic                    aw_valid_o;
   logic                    aw_ready_i;
   logic [LenWidth-1:0]     aw_len_o;
   logic                    w_valid_i;
   logic                    w_ready_o;
   logic [AxiDataWidth-1:0] w_data_i;
   logic [StrbWidth-1:0]    w_strb_i;
   logic                    w_valid_o;
   logic                    w_ready_i;
   logic [AxiDataWidth-1:0] w_data_o;
   logic [StrbWidth-1:0]    w_strb_o;
   logic                    w_last_o;
   logic                    b_valid_i;
   logic                    b_ready_o;
   logic [1:0]              b_resp_i;
   logic                    clr_err_i;
   logic                    idle_o;
   logic                    err_o;
   logic [CntW-1:0]         outstanding_o;

   modport slave (
      input  aw_valid_i, aw_len_i, aw_ready_i, w_valid_i, w_data_i, w_strb_i,
             w_ready_i, b_valid_i, b_resp_i, clr_err_i,
      output aw_ready_o, aw_valid_o, aw_len_o, w_ready_o, w_valid_o, w_data_o,
             w_strb_o, w_last_o, b_ready_o, idle_o, err_o, outstanding_o
   );

   modport master (
      output aw_valid_i, aw_len_i, aw_ready_i, w_valid_i, w_data_i, w_strb_i,
             w_ready_i, b_valid_i, b_resp_i, clr_err_i,
      input  aw_ready_o, aw_valid_o, aw_len_o, w_ready_o, w_valid_o, w_data_o,
             w_strb_o, w_last_o, b_ready_o, idle_o, err_o, outstanding_o
   );
endinterface

// File: rtl/store_w_gate.sv
// Pairs store-unit W beats with accepted AW bursts, generates WLAST from the recorded
// burst length, bounds outstanding bursts and tracks B completion / sticky error.
module store_w_gate #(
   parameter int AxiDataWidth   = 128,
   parameter int MaxOutstanding = 8,
   parameter int LenWidth       = 8
) (
   input logic           clk_i,
   input logic           rst_i,
   store_w_gate_if.slave bus
);
   localparam int PtrW = $clog2(MaxOutstanding);
   localparam int CntW = PtrW + 1;

   logic [CntW-1:0]     out_cnt;
   logic [CntW-1:0]     fifo_cnt;
   logic [PtrW-1:0]     wr_ptr;
   logic [PtrW-1:0]     rd_ptr;
   logic [LenWidth-1:0] len_mem [MaxOutstanding];
   logic [LenWidth-1:0] beat_cnt;
   logic                err_q;

   logic credit, has_head, w_last, aw_hs, w_hs, pop, b_hs;
   logic unused_resp;

   assign credit   = out_cnt < CntW'(MaxOutstanding);
   assign has_head = fifo_cnt != '0;
   assign w_last   = has_head && (beat_cnt == len_mem[rd_ptr]);

   assign bus.aw_valid_o = bus.aw_valid_i & credit;
   assign bus.aw_ready_o = bus.aw_ready_i & credit;
   assign bus.aw_len_o   = bus.aw_len_i;

   assign bus.w_valid_o = bus.w_valid_i & has_head;
   assign bus.w_ready_o = bus.w_ready_i & has_head;
   assign bus.w_data_o  = bus.w_data_i;
   assign bus.w_strb_o  = bus.w_strb_i;
   assign bus.w_last_o  = w_last;

   // B only needs a nonzero count; credit returns a cycle later via out_cnt.
   assign bus.b_ready_o = out_cnt != '0;

   assign aw_hs = bus.aw_valid_o & bus.aw_ready_i;
   assign w_hs  = bus.w_valid_o & bus.w_ready_i;
   assign pop   = w_hs & w_last;
   assign b_hs  = bus.b_valid_i & bus.b_ready_o;

   assign bus.idle_o        = (out_cnt == '0) && (fifo_cnt == '0);
   assign bus.err_o         = err_q;
   assign bus.outstanding_o = out_cnt;
   assign unused_resp       = bus.b_resp_i[0];

   always_ff @(posedge clk_i) begin
      if (aw_hs) len_mem[wr_ptr] <= bus.aw_len_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_cnt  <= '0;
         fifo_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         beat_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (aw_hs) wr_ptr <= wr_ptr + PtrW'(1);
         if (pop) begin
            rd_ptr   <= rd_ptr + PtrW'(1);
            beat_cnt <= '0;
         end else if (w_hs) begin
            beat_cnt <= beat_cnt + LenWidth'(1);
         end

         // Occupancy never exceeds out_cnt, so the len FIFO cannot overflow.
         case ({aw_hs, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CntW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CntW'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase

         case ({aw_hs, b_hs})
            2'b10:   out_cnt <= out_cnt + CntW'(1);
            2'b01:   out_cnt <= out_cnt - CntW'(1);
            default: out_cnt <= out_cnt;
         endcase

         // A new error wins over a same-cycle clear.
         if (b_hs && bus.b_resp_i[1]) err_q <= 1'b1;
         else if (bus.clr_err_i)      err_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_store_w_gate.sv
// Directed bench for store_w_gate: stimulus pushes expected AW/W traffic into queues,
// a negedge monitor pops and compares on every downstream handshake.
module tb_store_w_gate;
   localparam int DW = 128;
   localparam int SW = DW / 8;
   localparam int LW = 8;
   localparam int MO = 8;

   typedef struct packed {
      logic          last;
      logic [SW-1:0] strb;
      logic [DW-1:0] data;
   } wexp_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;

   store_w_gate_if #(.AxiDataWidth(DW), .MaxOutstanding(MO), .LenWidth(LW)) bus ();

   store_w_gate #(.AxiDataWidth(DW), .MaxOutstanding(MO), .LenWidth(LW)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   wexp_t         wq[$];
   logic [LW-1:0] awq[$];
   int            n_vec = 0;
   int            n_err = 0;
   int            beat_id = 0;
   int            wait_cyc;
   wexp_t         w_got, w_exp;
   logic [LW-1:0] aw_exp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every downstream AW / W handshake must match the queue head.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (bus.w_valid_o && bus.w_ready_i) begin
            w_got = {bus.w_last_o, bus.w_strb_o, bus.w_data_o};
            n_vec++;
            if (wq.size() == 0) begin
               n_err++;
               $display("FAIL w_unexpected: got last=%0b data=%h, expected no beat",
                        w_got.last, w_got.data);
            end else begin
               w_exp = wq.pop_front();
               if (w_got !== w_exp) begin
                  n_err++;
                  $display("FAIL w_beat: got last=%0b strb=%h data=%h expected last=%0b strb=%h data=%h",
                           w_got.last, w_got.strb, w_got.data, w_exp.last, w_exp.strb, w_exp.data);
               end
            end
         end
         if (bus.aw_valid_o && bus.aw_ready_i) begin
            n_vec++;
            if (awq.size() == 0) begin
               n_err++;
               $display("FAIL aw_unexpected: got len=%0d, expected no burst", bus.aw_len_o);
            end else begin
               aw_exp = awq.pop_front();
               if (bus.aw_len_o !== aw_exp) begin
                  n_err++;
                  $display("FAIL aw_len: got %0d expected %0d", bus.aw_len_o, aw_exp);
               end
            end
         end
      end
   end

   task automatic do_aw(input logic [LW-1:0] len);
      bus.aw_valid_i = 1'b1;
      bus.aw_len_i   = len;
      awq.push_back(len);
      @(posedge clk_i); #1;
      bus.aw_valid_i = 1'b0;
   endtask

   task automatic do_b(input logic [1:0] resp);
      bus.b_valid_i = 1'b1;
      bus.b_resp_i  = resp;
      @(posedge clk_i); #1;
      bus.b_valid_i = 1'b0;
      bus.b_resp_i  = 2'b00;
   endtask

   task automatic set_beat(input bit last);
      beat_id++;
      bus.w_data_i = {4{32'hA500_0000 + 32'(beat_id)}};
      bus.w_strb_i = 16'hFFFF ^ 16'(beat_id);
      wq.push_back({last, bus.w_strb_i, bus.w_data_i});
   endtask

   // Present one beat and hold it until the gate accepts it (bounded).
   task automatic send_w(input bit last);
      set_beat(last);
      bus.w_valid_i = 1'b1;
      wait_cyc = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_i);
         if (bus.w_ready_o) break;
         wait_cyc++;
      end
      if (!bus.w_ready_o) begin
         n_vec++;
         n_err++;
         $display("FAIL w_timeout: got w_ready_o=0 for 20 cycles expected 1");
      end
      @(posedge clk_i); #1;
      bus.w_valid_i = 1'b0;
   endtask

   initial begin
      bus.aw_valid_i = 1'b0; bus.aw_len_i = '0; bus.aw_ready_i = 1'b0;
      bus.w_valid_i  = 1'b0; bus.w_data_i = '0; bus.w_strb_i   = '0;
      bus.w_ready_i  = 1'b0; bus.b_valid_i = 1'b0; bus.b_resp_i = 2'b00;
      bus.clr_err_i  = 1'b0;

      // Reset state
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_aw_ready", bus.aw_ready_o, 0);
      chk("rst_aw_valid", bus.aw_valid_o, 0);
      chk("rst_w_valid",  bus.w_valid_o, 0);
      chk("rst_w_ready",  bus.w_ready_o, 0);
      chk("rst_w_last",   bus.w_last_o, 0);
      chk("rst_b_ready",  bus.b_ready_o, 0);
      chk("rst_idle",     bus.idle_o, 1);
      chk("rst_err",      bus.err_o, 0);
      chk("rst_out",      bus.outstanding_o, 0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      bus.aw_ready_i = 1'b1;
      bus.w_ready_i  = 1'b1;

      // Single burst len=3: beats accepted 1..4 cycles after AW, last on beat 4
      do_aw(8'd3);
      for (int i = 0; i < 4; i++) begin
         send_w(i == 3);
         chk("single_lat", wait_cyc, 0);
      end
      bus.w_valid_i = 1'b1;
      @(negedge clk_i);
      chk("single_fifo_empty", bus.w_valid_o, 0);
      chk("single_not_idle", bus.idle_o, 0);
      chk("single_b_ready", bus.b_ready_o, 1);
      @(posedge clk_i); #1;
      bus.w_valid_i = 1'b0;
      do_b(2'b00);
      @(negedge clk_i);
      chk("single_idle", bus.idle_o, 1);
      chk("single_err", bus.err_o, 0);

      // W before AW: blocked, then a len=0 burst lets exactly one beat through with last
      @(posedge clk_i); #1;
      set_beat(1'b1);
      bus.w_valid_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         chk("early_w_valid", bus.w_valid_o, 0);
         chk("early_w_ready", bus.w_ready_o, 0);
         @(posedge clk_i); #1;
      end
      do_aw(8'd0);
      @(negedge clk_i);
      chk("early_pass_ready", bus.w_ready_o, 1);
      chk("early_pass_last",  bus.w_last_o, 1);
      @(posedge clk_i); #1;
      bus.w_valid_i = 1'b0;
      do_b(2'b00);

      // Credit limit: 8 accepted, 9th blocked until one B frees credit the next cycle
      for (int i = 0; i < 8; i++) do_aw(8'd0);
      for (int i = 0; i < 8; i++) send_w(1'b1);
      bus.aw_valid_i = 1'b1;
      bus.aw_len_i   = 8'd0;
      @(negedge clk_i);
      chk("credit_out8",       bus.outstanding_o, 8);
      chk("credit_aw_valid0",  bus.aw_valid_o, 0);
      chk("credit_aw_ready0",  bus.aw_ready_o, 0);
      @(posedge clk_i); #1;
      bus.b_valid_i = 1'b1;
      @(negedge clk_i);
      chk("credit_b_same_cyc", bus.aw_valid_o, 0);
      @(posedge clk_i); #1;
      bus.b_valid_i = 1'b0;
      awq.push_back(8'd0);
      @(negedge clk_i);
      chk("credit_aw_valid1", bus.aw_valid_o, 1);
      chk("credit_out7",      bus.outstanding_o, 7);
      @(posedge clk_i); #1;
      bus.aw_valid_i = 1'b0;
      @(negedge clk_i);
      chk("credit_out8_again", bus.outstanding_o, 8);
      @(posedge clk_i); #1;
      send_w(1'b1);
      for (int i = 0; i < 8; i++) do_b(2'b00);
      @(negedge clk_i);
      chk("credit_idle", bus.idle_o, 1);
      @(posedge clk_i); #1;

      // Back-to-back bursts lens 1,0,2: last on beats 2,3,6
      do_aw(8'd1); do_aw(8'd0); do_aw(8'd2);
      send_w(1'b0); send_w(1'b1); send_w(1'b1);
      send_w(1'b0); send_w(1'b0); send_w(1'b1);
      // Push and pop in the same cycle at occupancy 1
      do_aw(8'd1);
      send_w(1'b0);
      bus.aw_valid_i = 1'b1;
      bus.aw_len_i   = 8'd0;
      awq.push_back(8'd0);
      send_w(1'b1);
      bus.aw_valid_i = 1'b0;
      send_w(1'b1);
      chk("b2b_lat", wait_cyc, 0);
      @(negedge clk_i);
      chk("b2b_out5", bus.outstanding_o, 5);
      @(posedge clk_i); #1;
      for (int i = 0; i < 5; i++) do_b(2'b00);

      // Simultaneous AW and B at out_cnt=3, then sticky error and clear
      for (int i = 0; i < 3; i++) do_aw(8'd0);
      for (int i = 0; i < 3; i++) send_w(1'b1);
      @(negedge clk_i);
      chk("sim_out3_pre", bus.outstanding_o, 3);
      @(posedge clk_i); #1;
      bus.b_valid_i = 1'b1;
      do_aw(8'd0);
      bus.b_valid_i = 1'b0;
      @(negedge clk_i);
      chk("sim_out3_post", bus.outstanding_o, 3);
      @(posedge clk_i); #1;
      send_w(1'b1);
      do_b(2'b10);
      @(negedge clk_i);
      chk("err_set", bus.err_o, 1);
      chk("err_out2", bus.outstanding_o, 2);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("err_held", bus.err_o, 1);
      @(posedge clk_i); #1;
      bus.clr_err_i = 1'b1;
      @(posedge clk_i); #1;
      bus.clr_err_i = 1'b0;
      @(negedge clk_i);
      chk("err_cleared", bus.err_o, 0);
      @(posedge clk_i); #1;
      bus.clr_err_i = 1'b1;
      do_b(2'b11);
      bus.clr_err_i = 1'b0;
      @(negedge clk_i);
      chk("err_clr_vs_new", bus.err_o, 1);
      @(posedge clk_i); #1;
      bus.clr_err_i = 1'b1;
      @(posedge clk_i); #1;
      bus.clr_err_i = 1'b0;
      do_b(2'b00);
      @(negedge clk_i);
      chk("err_final", bus.err_o, 0);
      chk("err_idle",  bus.idle_o, 1);
      @(posedge clk_i); #1;

      // Reset mid-burst after 2 of 4 beats
      do_aw(8'd3);
      send_w(1'b0); send_w(1'b0);
      bus.w_valid_i = 1'b1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("mid_rst_idle",    bus.idle_o, 1);
      chk("mid_rst_out",     bus.outstanding_o, 0);
      chk("mid_rst_w_ready", bus.w_ready_o, 0);
      @(posedge clk_i); #1;
      bus.w_valid_i = 1'b0;

      chk("end_wq_empty",  wq.size(), 0);
      chk("end_awq_empty", awq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/store_w_gate.md
Name: store_w_gate

Overview:
- Sits directly downstream of the vector store unit, between its AXI W output and the AXI master port.
- Pairs each W beat with an accepted AW burst and generates WLAST from the recorded burst length.
- Bounds outstanding write bursts, consumes B responses, and reports store completion (idle) and a sticky error to the VLSU controller.

Parameters:
AxiDataWidth, 128, W data width in bits; strobe width is AxiDataWidth/8.
MaxOutstanding, 8, maximum AW bursts accepted without a B response; power of two, ≥2.
LenWidth, 8, AXI AxLEN width (beats-1).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
aw_valid_i  in  1  burst request from address generator
aw_ready_o  out  1  burst request accepted
aw_len_i  in  LenWidth  burst beats-1
aw_valid_o  out  1  AW valid to AXI
aw_ready_i  in  1  AW ready from AXI
aw_len_o  out  LenWidth  AW len to AXI (= aw_len_i)
w_valid_i  in  1  beat from store unit (carries no last)
w_ready_o  out  1  beat accepted
w_data_i  in  AxiDataWidth  beat data
w_strb_i  in  AxiDataWidth/8  beat strobes
w_valid_o  out  1  W valid to AXI
w_ready_i  in  1  W ready from AXI
w_data_o  out  AxiDataWidth  = w_data_i
w_strb_o  out  AxiDataWidth/8  = w_strb_i
w_last_o  out  1  last beat of head burst
b_valid_i  in  1  B response valid
b_ready_o  out  1  B response accepted
b_resp_i  in  2  AXI BRESP
clr_err_i  in  1  clears err_o
idle_o  out  1  no bursts outstanding, no pending W
err_o  out  1  sticky: a B response was SLVERR/DECERR
outstanding_o  out  $clog2(MaxOutstanding)+1  current outstanding burst count

Behaviour:
- Reset (rst_i high at a clock edge): out_cnt=0, len FIFO empty, beat_cnt=0, err=0.
  - Resulting outputs: aw_ready_o=0, aw_valid_o=0, w_valid_o=0, w_ready_o=0, w_last_o=0, b_ready_o=0, idle_o=1, err_o=0, outstanding_o=0.
  - Reset mid-burst discards all state; the environment must also be reset.
- Credit: credit = (out_cnt < MaxOutstanding).
  - aw_valid_o = aw_valid_i & credit; aw_ready_o = aw_ready_i & credit.
  - This is a combinational pass-through, 0-cycle latency.
- AW handshake (aw_valid_o & aw_ready_i): push aw_len_i into the len FIFO (depth MaxOutstanding) and increment out_cnt.
  - The FIFO cannot overflow because FIFO occupancy ≤ out_cnt.
- W gating: has_head = FIFO non-empty (registered occupancy).
  - w_valid_o = w_valid_i & has_head; w_ready_o = w_ready_i & has_head.
  - A burst pushed in cycle N enables W from cycle N+1; AW-to-first-W latency is 1 cycle minimum.
- Beat counter (width LenWidth):
  - w_last_o = has_head & (beat_cnt == FIFO head len).
  - On a W handshake: if w_last_o, pop the FIFO and set beat_cnt=0; else beat_cnt+1.
  - len=0 gives a single beat with w_last_o=1.
  - Simultaneous pop and push is legal; occupancy is unchanged. The push lands at the tail, so the head advances correctly, including when occupancy was 1.
- B channel: b_ready_o = (out_cnt != 0). On a B handshake, decrement out_cnt.
  - Simultaneous AW and B handshakes leave out_cnt unchanged.
  - When out_cnt == MaxOutstanding, a B handshake frees credit the next cycle (no combinational B-to-AW path).
- Error: on a B handshake with b_resp_i[1]==1, err=1. clr_err_i clears err; a simultaneous clear and new error leaves err=1.
- idle_o = (out_cnt==0) & FIFO empty; registered-state decode only.
- outstanding_o = out_cnt.
- Counter arithmetic is unsigned; out_cnt never underflows because b_ready_o=0 at zero.
- FIFO pointers are $clog2(MaxOutstanding) bits and wrap modulo MaxOutstanding.

Test Plan:
- Single burst: AW len=3, then 4 W beats with w_ready_i=1 → W accepted cycles 1–4 after AW; w_last_o only on 4th beat; FIFO empty after; B OKAY → idle_o=1, err_o=0.
- W before AW: w_valid_i=1 for 5 cycles with no AW → w_valid_o=0, w_ready_o=0 throughout; AW len=0 → one beat passes the next cycle with w_last_o=1.
- Credit limit (MaxOutstanding=8): 9 AWs with B held off → first 8 accepted, aw_valid_o=0 for the 9th, outstanding_o=8; one B → 9th AW accepted the following cycle.
- Back-to-back bursts: lens 1,0,2 pre-queued, continuous W → w_last_o on beats 2, 3, 6; FIFO pop/push in the same cycle keeps order.
- Simultaneous AW and B at out_cnt=3 → out_cnt stays 3; B with resp=2'b10 → err_o=1, held until clr_err_i, then 0.
- Reset mid-burst after 2 of 4 beats → next cycle idle_o=1, outstanding_o=0, w_ready_o=0.
